// File: rtl/seq_det_param.sv
// Serial pattern detector with a runtime-loadable pattern, length and overlap mode.
// Emits a registered one-cycle match pulse and keeps a saturating match count.
module seq_det_param #(
  parameter int unsigned        MAX_LEN = 8,
  parameter int unsigned        CNT_W   = 8,
  parameter logic [MAX_LEN-1:0] DEF_PAT = 8'b0000_1011,
  parameter int unsigned        DEF_LEN = 4,
  parameter bit                 DEF_OVL = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cfg_we,
  input  logic [MAX_LEN-1:0]       cfg_pat,
  input  logic [$clog2(MAX_LEN):0] cfg_len,
  input  logic                     cfg_ovl,
  input  logic                     in_valid,
  input  logic                     in_d,
  output logic                     dout,
  output logic [CNT_W-1:0]         match_cnt,
  output logic                     cfg_err
);

  localparam int unsigned LW = $clog2(MAX_LEN) + 1;

  logic [MAX_LEN-1:0] r_pat;
  logic [LW-1:0]      r_len;
  logic               r_ovl;
  logic [MAX_LEN-1:0] r_hist;
  logic [LW-1:0]      r_fill;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_dout;
  logic               r_err;

  logic [MAX_LEN-1:0] w_mask;
  logic [MAX_LEN-1:0] w_hist_nxt;
  logic [LW:0]        w_fill_inc;
  logic               w_accept;
  logic               w_match;
  logic               w_cfg_ok;

  // Only the low len bits take part in the comparison.
  always_comb begin
    w_mask = '0;
    for (int unsigned i = 0; i < MAX_LEN; i++) begin
      w_mask[i] = (i < 32'(r_len));
    end
  end

  assign w_hist_nxt = {r_hist[MAX_LEN-2:0], in_d};
  assign w_fill_inc = {1'b0, r_fill} + (LW+1)'(1);
  assign w_accept   = in_valid && !cfg_we;
  assign w_match    = w_accept && (w_fill_inc >= {1'b0, r_len}) &&
                      (((w_hist_nxt ^ r_pat) & w_mask) == '0);
  assign w_cfg_ok   = (cfg_len != '0) && (cfg_len <= LW'(MAX_LEN));

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pat  <= DEF_PAT;
      r_len  <= LW'(DEF_LEN);
      r_ovl  <= DEF_OVL;
      r_hist <= '0;
      r_fill <= '0;
      r_cnt  <= '0;
      r_dout <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_dout <= 1'b0;
      r_err  <= 1'b0;
      if (cfg_we) begin
        if (w_cfg_ok) begin
          r_pat  <= cfg_pat;
          r_len  <= cfg_len;
          r_ovl  <= cfg_ovl;
          r_hist <= '0;
          r_fill <= '0;
        end else begin
          r_err <= 1'b1;
        end
      end else if (in_valid) begin
        r_hist <= w_hist_nxt;
        if (w_match) begin
          r_dout <= 1'b1;
          r_fill <= r_ovl ? r_len : '0;
          if (r_cnt != '1) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end else if (r_fill != r_len) begin
          r_fill <= r_fill + LW'(1);
        end
      end
    end
  end

  assign dout      = r_dout;
  assign match_cnt = r_cnt;
  assign cfg_err   = r_err;

endmodule

// File: tb/tb_seq_det_param.sv
// Scoreboard bench for seq_det_param: a bit-queue reference model predicts each
// cycle's outputs, and a negedge monitor compares two DUTs (CNT_W=8 and CNT_W=2).
module tb_seq_det_param;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cfg_we = 1'b0;
  logic [7:0] cfg_pat = '0;
  logic [3:0] cfg_len = '0;
  logic       cfg_ovl = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_d = 1'b0;
  logic       dout8, err8, dout2, err2;
  logic [7:0] cnt8;
  logic [1:0] cnt2;

  always #5 clk = ~clk;

  seq_det_param u_dut8 (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pat(cfg_pat), .cfg_len(cfg_len),
    .cfg_ovl(cfg_ovl), .in_valid(in_valid), .in_d(in_d),
    .dout(dout8), .match_cnt(cnt8), .cfg_err(err8)
  );

  seq_det_param #(.CNT_W(2)) u_dut2 (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pat(cfg_pat), .cfg_len(cfg_len),
    .cfg_ovl(cfg_ovl), .in_valid(in_valid), .in_d(in_d),
    .dout(dout2), .match_cnt(cnt2), .cfg_err(err2)
  );

  typedef struct packed {
    logic       dout;
    logic [7:0] c8;
    logic [1:0] c2;
    logic       err;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   pulses = 0;

  // Reference model state: bits received since the last clear, and the active config.
  bit   hist_q[$];
  logic [7:0] m_pat;
  int   m_len;
  bit   m_ovl;
  int   m_cnt;

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      if (dout8) pulses++;
      n_cmp++; if (dout8 !== e.dout) begin n_bad++; $display("FAIL dout: got %b want %b @%0t", dout8, e.dout, $time); end
      n_cmp++; if (dout2 !== e.dout) begin n_bad++; $display("FAIL dout_w2: got %b want %b @%0t", dout2, e.dout, $time); end
      n_cmp++; if (cnt8 !== e.c8) begin n_bad++; $display("FAIL cnt8: got %0d want %0d @%0t", cnt8, e.c8, $time); end
      n_cmp++; if (cnt2 !== e.c2) begin n_bad++; $display("FAIL cnt2: got %0d want %0d @%0t", cnt2, e.c2, $time); end
      n_cmp++; if (err8 !== e.err) begin n_bad++; $display("FAIL cfg_err: got %b want %b @%0t", err8, e.err, $time); end
      n_cmp++; if (err2 !== e.err) begin n_bad++; $display("FAIL cfg_err_w2: got %b want %b @%0t", err2, e.err, $time); end
    end
  end

  task automatic step(input bit rn, input bit we, input logic [7:0] p, input int l,
                      input bit o, input bit v, input bit d);
    exp_t e;
    bit   hit;
    @(negedge clk); #1;
    rst = rn; cfg_we = we; cfg_pat = p; cfg_len = 4'(l); cfg_ovl = o;
    in_valid = v; in_d = d;
    e.dout = 1'b0;
    e.err  = 1'b0;
    if (!rn) begin
      m_pat = 8'b0000_1011; m_len = 4; m_ovl = 1'b0; m_cnt = 0;
      hist_q.delete();
    end else if (we) begin
      if (l >= 1 && l <= 8) begin
        m_pat = p; m_len = l; m_ovl = o;
        hist_q.delete();
      end else begin
        e.err = 1'b1;
      end
    end else if (v) begin
      hist_q.push_back(d);
      if (hist_q.size() > 8) void'(hist_q.pop_front());
      if (hist_q.size() >= m_len) begin
        hit = 1'b1;
        for (int k = 0; k < m_len; k++)
          if (hist_q[hist_q.size() - m_len + k] != m_pat[m_len - 1 - k]) hit = 1'b0;
        if (hit) begin
          e.dout = 1'b1;
          m_cnt++;
          if (!m_ovl) hist_q.delete();
        end
      end
    end
    e.c8 = (m_cnt > 255) ? 8'd255 : 8'(m_cnt);
    e.c2 = (m_cnt > 3) ? 2'd3 : 2'(m_cnt);
    exp_q.push_back(e);
    @(posedge clk);
  endtask

  task automatic idle();
    step(1, 0, 8'h00, 0, 0, 0, 0);
  endtask

  task automatic bits(input logic [31:0] b, input int n, input int gap);
    for (int i = n - 1; i >= 0; i--) begin
      step(1, 0, 8'h00, 0, 0, 1, b[i]);
      for (int g = 0; g < gap; g++) idle();
    end
  endtask

  task automatic cfg(input logic [7:0] p, input int l, input bit o);
    step(1, 1, p, l, o, 0, 0);
  endtask

  task automatic do_reset();
    step(0, 0, 8'h00, 0, 0, 0, 0);
  endtask

  task automatic check_pulses(input string name, input int start, input int want);
    idle();
    idle();
    n_cmp++;
    if (pulses - start !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d pulses want %0d", name, pulses - start, want);
    end
  endtask

  initial begin
    int s;
    do_reset();
    do_reset();

    s = pulses; bits(32'b1011011, 7, 0); check_pulses("defaults_1011", s, 1);

    cfg(8'b1011, 4, 1);
    s = pulses; bits(32'b1011011, 7, 0); check_pulses("overlap_1011", s, 2);

    cfg(8'b111, 3, 1);
    s = pulses; bits(32'b11111, 5, 0); check_pulses("ovl_111", s, 3);
    cfg(8'b111, 3, 0);
    s = pulses; bits(32'b11111, 5, 0); check_pulses("novl_111", s, 1);

    do_reset();
    cfg(8'hFF, 0, 1);
    cfg(8'hFF, 9, 1);
    s = pulses; bits(32'b1011, 4, 0); check_pulses("cfg_reject_keeps_default", s, 1);

    do_reset();
    s = pulses; bits(32'b101, 3, 0); do_reset(); bits(32'b1, 1, 0);
    check_pulses("reset_discards_partial", s, 0);
    s = pulses; bits(32'b1011, 4, 2); check_pulses("gapped_1011", s, 1);

    do_reset();
    s = pulses; for (int i = 0; i < 5; i++) bits(32'b1011, 4, 0);
    check_pulses("five_1011_sat", s, 5);

    // cfg_we and in_valid together: the data bit must be dropped.
    step(1, 1, 8'b1, 1, 1, 1, 1);
    step(1, 1, 8'b1, 1, 1, 1, 1);

    for (int i = 0; i < 3000; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 1) do_reset();
      else if (r < 6) begin
        int l;
        l = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 9) : $urandom_range(1, 4);
        step(1, 1, 8'($urandom), l, 1'($urandom), 1'($urandom), 1'($urandom));
      end else
        step(1, 0, 8'($urandom), $urandom_range(0, 15), 1'($urandom),
             $urandom_range(0, 3) != 0, 1'($urandom));
    end

    for (int t = 0; t < 10 && exp_q.size() > 0; t++) @(posedge clk);
    @(negedge clk); #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
